// File: rtl/rtc_access_sched.sv
// rtc_access_sched: grants the shared RTC bus to the init/write/read sequencers, paces read refreshes, aborts hung transactions.
module rtc_access_sched #(
    parameter int REFRESH_CYC = 100000,
    parameter int TIMEOUT_CYC = 1023,
    parameter int GUARD_CYC   = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_req,
    input  logic       init_ready,
    input  logic       wr_ready,
    input  logic       rd_ready,
    output logic       inicializar,
    output logic       escribir,
    output logic       leer,
    output logic [1:0] bus_sel,
    output logic       wr_ack,
    output logic       data_valid,
    output logic       timeout_err,
    output logic       busy
);
    localparam int RW   = $clog2(REFRESH_CYC + 1);
    localparam int MAXC = TIMEOUT_CYC > GUARD_CYC ? TIMEOUT_CYC : GUARD_CYC;
    localparam int CW   = $clog2(MAXC + 1);

    // Low two bits of each granted state equal its bus_sel code.
    typedef enum logic [2:0] {IDLE = 3'd0, INIT = 3'd1, WRITE = 3'd2, READ = 3'd3, RELEASE = 3'd4} state_t;

    state_t        state, nxt;
    logic [RW-1:0] ref_cnt;
    logic [CW-1:0] cnt;
    logic [1:0]    owner;
    logic          init_pend, rd_pend, last_was_wr;
    logic          ref_wrap, rdy, granted, done, tmo;

    always_comb begin
        ref_wrap = ref_cnt == RW'(REFRESH_CYC - 1);
        rdy      = owner == 2'b01 ? init_ready : owner == 2'b10 ? wr_ready : owner == 2'b11 ? rd_ready : 1'b0;
        granted  = state inside {INIT, WRITE, READ};
        done     = granted && rdy;
        tmo      = granted && !rdy && cnt == CW'(TIMEOUT_CYC - 1);
        nxt      = state;
        case (state)
            IDLE:    nxt = init_pend ? INIT : (rd_pend && last_was_wr) ? READ : wr_req ? WRITE : rd_pend ? READ : IDLE;
            RELEASE: nxt = (cnt >= CW'(GUARD_CYC - 1) && !rdy) ? IDLE : RELEASE;
            default: nxt = (done || tmo) ? RELEASE : state;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            ref_cnt     <= '0;
            cnt         <= '0;
            owner       <= 2'b00;
            init_pend   <= 1'b1;
            rd_pend     <= 1'b0;
            last_was_wr <= 1'b0;
            inicializar <= 1'b0;
            escribir    <= 1'b0;
            leer        <= 1'b0;
            bus_sel     <= 2'b00;
            wr_ack      <= 1'b0;
            data_valid  <= 1'b0;
            timeout_err <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= nxt;
            ref_cnt     <= ref_wrap ? '0 : ref_cnt + 1'b1;
            // One counter serves as timeout in granted states and guard in RELEASE.
            cnt         <= nxt != state ? '0 : &cnt ? cnt : cnt + 1'b1;
            owner       <= nxt inside {INIT, WRITE, READ} ? nxt[1:0] : owner;
            init_pend   <= init_pend && !(done && state == INIT);
            rd_pend     <= ref_wrap || (rd_pend && !((done || tmo) && state == READ));
            last_was_wr <= (done && state != INIT) ? state == WRITE : last_was_wr;
            timeout_err <= tmo || (timeout_err && !done);
            inicializar <= nxt == INIT;
            escribir    <= nxt == WRITE;
            leer        <= nxt == READ;
            bus_sel     <= nxt[1:0];
            wr_ack      <= done && state == WRITE;
            data_valid  <= done && state == READ;
            busy        <= nxt != IDLE;
        end
    end
endmodule

// File: tb/tb_rtc_access_sched.sv
// tb_rtc_access_sched: scenario tasks plus an event scoreboard for rtc_access_sched.
module tb_rtc_access_sched;
    localparam int RC = 200;
    localparam int TC = 50;
    localparam int GC = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       wr_req = 1'b0;
    logic       init_ready = 1'b0;
    logic       wr_ready = 1'b0;
    logic       rd_ready = 1'b0;
    logic       inicializar, escribir, leer, wr_ack, data_valid, timeout_err, busy;
    logic [1:0] bus_sel;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    // Event codes: 1/2/3 = INIT/WRITE/READ grant, 4 = wr_ack, 5 = data_valid.
    int exp_q[$];
    int lat[1:3] = '{30, 40, 5};
    int hold[1:3] = '{1, 1, 1};

    always #5 clk = ~clk;

    rtc_access_sched #(.REFRESH_CYC(RC), .TIMEOUT_CYC(TC), .GUARD_CYC(GC)) dut (
        .clk(clk), .reset(reset), .wr_req(wr_req),
        .init_ready(init_ready), .wr_ready(wr_ready), .rd_ready(rd_ready),
        .inicializar(inicializar), .escribir(escribir), .leer(leer), .bus_sel(bus_sel),
        .wr_ack(wr_ack), .data_valid(data_valid), .timeout_err(timeout_err), .busy(busy)
    );

    // Sequencer models: ready rises lat cycles after start (0 = never) and stays high hold cycles.
    initial begin
        int   scnt[1:3];
        int   left[1:3];
        logic st[1:3];
        logic rdy[1:3];
        scnt = '{0, 0, 0};
        left = '{0, 0, 0};
        forever begin
            @(negedge clk);
            st[1] = inicializar;
            st[2] = escribir;
            st[3] = leer;
            for (int k = 1; k <= 3; k++) begin
                if (!reset) begin
                    scnt[k] = 0;
                    left[k] = 0;
                end else begin
                    scnt[k] = st[k] ? scnt[k] + 1 : 0;
                    if (st[k] && scnt[k] == lat[k]) left[k] = hold[k];
                end
                rdy[k] = left[k] > 0;
                if (left[k] > 0) left[k]--;
            end
            init_ready = rdy[1];
            wr_ready   = rdy[2];
            rd_ready   = rdy[3];
        end
    end

    // Scoreboard monitor: every grant/ack/valid must match the head of exp_q.
    initial begin
        int         ev[$];
        int         e;
        logic       pb;
        logic [1:0] es;
        pb = 1'b0;
        forever begin
            @(negedge clk);
            cyc = reset ? cyc + 1 : 0;
            ev = {};
            if (busy && !pb) ev.push_back(int'(bus_sel));
            if (wr_ack) ev.push_back(4);
            if (data_valid) ev.push_back(5);
            pb = busy;
            foreach (ev[i]) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL sb_unexpected: cycle %0d got event %0d, expected none", cyc, ev[i]);
                end else begin
                    e = exp_q.pop_front();
                    if (ev[i] !== e) begin
                        fails++;
                        $display("FAIL sb_event: cycle %0d got event %0d, expected %0d", cyc, ev[i], e);
                    end
                end
            end
            es = leer ? 2'b11 : escribir ? 2'b10 : inicializar ? 2'b01 : 2'b00;
            tests++;
            if (bus_sel !== es || $countones({inicializar, escribir, leer}) > 1 ||
                ((wr_ack || data_valid) && bus_sel !== 2'b00)) begin
                fails++;
                $display("FAIL bus_consistency: cycle %0d bus_sel=%b starts=%b%b%b ack=%b dv=%b",
                         cyc, bus_sel, inicializar, escribir, leer, wr_ack, data_valid);
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic hold_reset();
        reset = 1'b0;
        repeat (3) tick();
    endtask

    task automatic release_reset();
        @(negedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic wait_q(input int lim);
        int i = 0;
        while (exp_q.size() != 0 && i < lim) begin
            tick();
            i++;
        end
    endtask

    task automatic test_reset();
        int rel = 0;
        hold_reset();
        tests++;
        if ({inicializar, escribir, leer, wr_ack, data_valid, timeout_err, busy, bus_sel} !== 9'b0) begin
            fails++;
            $display("FAIL reset_outputs: got %b, expected all zero",
                     {inicializar, escribir, leer, wr_ack, data_valid, timeout_err, busy, bus_sel});
        end
        exp_q.push_back(1);
        release_reset();
        tick();
        tests++;
        if (inicializar !== 1'b1 || bus_sel !== 2'b01 || cyc != 1) begin
            fails++;
            $display("FAIL first_grant: cycle %0d inicializar=%b bus_sel=%b, expected cycle 1 with 1/01", cyc, inicializar, bus_sel);
        end
        for (int i = 0; i < 40; i++) begin
            tick();
            if (busy && bus_sel == 2'b00) rel++;
        end
        tests++;
        if (rel != GC) begin
            fails++;
            $display("FAIL init_guard: release cycles %0d, expected %0d", rel, GC);
        end
        tests++;
        if (busy !== 1'b0 || bus_sel !== 2'b00 || exp_q.size() != 0) begin
            fails++;
            $display("FAIL init_done: busy=%b bus_sel=%b pending=%0d, expected 0/00/0", busy, bus_sel, exp_q.size());
        end
    endtask

    task automatic test_refresh();
        int n, c1, c2;
        exp_q.push_back(3); exp_q.push_back(5); exp_q.push_back(3); exp_q.push_back(5);
        n = 0;
        while (!leer && n < 400) begin tick(); n++; end
        c1 = cyc;
        n = 0;
        while (leer && n < 100) begin tick(); n++; end
        n = 0;
        while (!leer && n < 400) begin tick(); n++; end
        c2 = cyc;
        tests++;
        if (c1 != RC + 1) begin
            fails++;
            $display("FAIL refresh_first: leer at cycle %0d, expected %0d", c1, RC + 1);
        end
        tests++;
        if (c2 - c1 != RC) begin
            fails++;
            $display("FAIL refresh_period: period %0d, expected %0d", c2 - c1, RC);
        end
        wait_q(40);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL refresh_events: %0d events missing, expected 0", exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        hold_reset();
        wr_req = 1'b1;
        exp_q.push_back(1);
        for (int r = 0; r < 2; r++) begin
            for (int w = 0; w < 4; w++) begin exp_q.push_back(2); exp_q.push_back(4); end
            exp_q.push_back(3);
            exp_q.push_back(5);
        end
        release_reset();
        wait_q(600);
        wr_req = 1'b0;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL alternate_events: %0d events missing at cycle %0d, expected 0", exp_q.size(), cyc);
        end
        repeat (20) tick();
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL alternate_idle: busy=%b, expected 0", busy);
        end
    endtask

    task automatic test_timeout();
        int n;
        hold_reset();
        wr_req = 1'b1;
        lat[2] = 0;
        exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(2); exp_q.push_back(4);
        release_reset();
        n = 0;
        while (!escribir && n < 100) begin tick(); n++; end
        n = 0;
        while (escribir && n < 200) begin tick(); n++; end
        tests++;
        if (n != TC) begin
            fails++;
            $display("FAIL timeout_len: escribir high %0d cycles, expected %0d", n, TC);
        end
        tests++;
        if (timeout_err !== 1'b1 || busy !== 1'b1 || bus_sel !== 2'b00) begin
            fails++;
            $display("FAIL timeout_flag: err=%b busy=%b bus_sel=%b, expected 1/1/00", timeout_err, busy, bus_sel);
        end
        lat[2] = 10;
        wait_q(100);
        wr_req = 1'b0;
        tests++;
        if (exp_q.size() != 0 || timeout_err !== 1'b0) begin
            fails++;
            $display("FAIL timeout_retry: pending=%0d err=%b, expected 0/0", exp_q.size(), timeout_err);
        end
        lat[2] = 40;
    endtask

    task automatic test_guard_hold();
        int n;
        hold_reset();
        hold[3] = 10;
        lat[2] = 10;
        exp_q.push_back(1); exp_q.push_back(3); exp_q.push_back(5); exp_q.push_back(2); exp_q.push_back(4);
        release_reset();
        n = 0;
        while (!leer && n < 400) begin tick(); n++; end
        wr_req = 1'b1;
        n = 0;
        while (leer && n < 100) begin tick(); n++; end
        n = 0;
        while (busy && bus_sel == 2'b00 && n < 100) begin tick(); n++; end
        tests++;
        if (n != 10) begin
            fails++;
            $display("FAIL guard_hold: release lasted %0d cycles, expected 10", n);
        end
        tick();
        tests++;
        if (escribir !== 1'b1 || bus_sel !== 2'b10) begin
            fails++;
            $display("FAIL guard_regrant: escribir=%b bus_sel=%b, expected 1/10", escribir, bus_sel);
        end
        wr_req = 1'b0;
        wait_q(50);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL wr_drop_ack: %0d events missing, expected 0", exp_q.size());
        end
        hold[3] = 1;
        lat[2] = 40;
    endtask

    task automatic test_reset_mid_read();
        int n;
        hold_reset();
        lat[3] = 20;
        exp_q.push_back(1); exp_q.push_back(3);
        release_reset();
        n = 0;
        while (!leer && n < 400) begin tick(); n++; end
        tick();
        reset = 1'b0;
        #1;
        tests++;
        if (leer !== 1'b0 || bus_sel !== 2'b00 || busy !== 1'b0 || exp_q.size() != 0) begin
            fails++;
            $display("FAIL midread_reset: leer=%b bus_sel=%b busy=%b pending=%0d, expected 0/00/0/0",
                     leer, bus_sel, busy, exp_q.size());
        end
        exp_q.push_back(1);
        release_reset();
        tick();
        tests++;
        if (inicializar !== 1'b1 || bus_sel !== 2'b01) begin
            fails++;
            $display("FAIL midread_regrant: inicializar=%b bus_sel=%b, expected 1/01", inicializar, bus_sel);
        end
        repeat (40) tick();
        tests++;
        if (exp_q.size() != 0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL midread_end: pending=%0d busy=%b, expected 0/0", exp_q.size(), busy);
        end
        lat[3] = 5;
    endtask

    initial begin
        test_reset();
        test_refresh();
        test_back_to_back();
        test_timeout();
        test_guard_hold();
        test_reset_mid_read();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
